// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register bank with NUM_RW control registers at 0x000 and NUM_RO
// status words at 0x100. Single-beat transactions only. The write and read
// channels are independent FSMs that can run at the same time. The bank
// raises one-cycle write and read strobes for side effects further downstream.
module axi_lite_reg_slave #(
    parameter int ADDR_W = 15,
    parameter int NUM_RW = 8,
    parameter int NUM_RO = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ADDR_W-1:0]        s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [ADDR_W-1:0]        s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [NUM_RW*32-1:0]     reg_rw_out,
    input  logic [NUM_RO*32-1:0]     reg_ro_in,
    output logic [NUM_RW-1:0]        wr_pulse,
    output logic [NUM_RO-1:0]        rd_pulse
);

    localparam int          IDX_W   = ADDR_W - 2;
    localparam logic [31:0] RW_END  = 32'(NUM_RW);
    localparam logic [31:0] RO_BASE = 32'd64;
    localparam logic [31:0] RO_END  = 32'(64 + NUM_RO);
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_RESP } rstate_t;

    // Register storage and channel state
    logic [31:0]        r_regs [NUM_RW];
    logic [NUM_RW-1:0]  r_wr_pulse;

    wstate_t            r_wstate;
    logic               r_awready;
    logic               r_wready;
    logic               r_aw_held;
    logic               r_w_held;
    logic [IDX_W-1:0]   r_aw_word;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_bvalid;
    logic [1:0]         r_bresp;

    rstate_t            r_rstate;
    logic               r_arready;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;
    logic [NUM_RO-1:0]  r_rd_pulse;

    // Write-side combinational view: what commits if this edge completes the pair
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_aw_next;
    logic               w_w_next;
    logic               w_commit;
    logic [31:0]        w_wr_word;
    logic [31:0]        w_wr_data;
    logic [3:0]         w_wr_strb;
    logic               w_wr_rw_hit;

    // Read-side combinational view
    logic               w_ar_hs;
    logic [31:0]        w_rd_word;
    logic               w_rd_rw_hit;
    logic               w_rd_ro_hit;
    logic [31:0]        w_rd_data;
    logic [NUM_RO-1:0]  w_rd_onehot;

    // Byte-lane address bits play no part in the decode
    logic               w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign w_aw_hs     = s_axi_awvalid && r_awready;
    assign w_w_hs      = s_axi_wvalid && r_wready;
    assign w_aw_next   = r_aw_held || w_aw_hs;
    assign w_w_next    = r_w_held || w_w_hs;
    assign w_commit    = (r_wstate == W_IDLE) && w_aw_next && w_w_next;
    assign w_wr_word   = w_aw_hs ? 32'(s_axi_awaddr[ADDR_W-1:2]) : 32'(r_aw_word);
    assign w_wr_data   = w_w_hs ? s_axi_wdata : r_wdata;
    assign w_wr_strb   = w_w_hs ? s_axi_wstrb : r_wstrb;
    assign w_wr_rw_hit = (w_wr_word < RW_END);

    assign w_ar_hs     = s_axi_arvalid && r_arready;
    assign w_rd_word   = 32'(s_axi_araddr[ADDR_W-1:2]);
    assign w_rd_rw_hit = (w_rd_word < RW_END);
    assign w_rd_ro_hit = (w_rd_word >= RO_BASE) && (w_rd_word < RO_END);

    // Read data mux and RO strobe decode; unmapped words fall through as zero
    always_comb begin
        w_rd_data   = '0;
        w_rd_onehot = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (w_rd_word == 32'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if (w_rd_word == RO_BASE + 32'(i)) begin
                w_rd_data      = reg_ro_in[32*i +: 32];
                w_rd_onehot[i] = 1'b1;
            end
        end
    end

    // RW register file: byte-masked update and write strobe on a committed RW hit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit && w_wr_rw_hit) begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (w_wr_word == 32'(i)) begin
                        r_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (w_wr_strb[b]) begin
                                r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Write FSM: collect AW and W in either order, commit, then hold B until taken
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_word <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_rw_hit ? OKAY : SLVERR;
                        r_wstate  <= W_RESP;
                    end else begin
                        r_aw_held <= w_aw_next;
                        r_w_held  <= w_w_next;
                        r_awready <= !w_aw_next;
                        r_wready  <= !w_w_next;
                        if (w_aw_hs) begin
                            r_aw_word <= s_axi_awaddr[ADDR_W-1:2];
                        end
                        if (w_w_hs) begin
                            r_wdata <= s_axi_wdata;
                            r_wstrb <= s_axi_wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Read FSM: sample data at AR acceptance, hold R stable until taken
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstate   <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= OKAY;
            r_rd_pulse <= '0;
        end else begin
            r_rd_pulse <= '0;
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata    <= w_rd_data;
                        r_rresp    <= (w_rd_rw_hit || w_rd_ro_hit) ? OKAY : SLVERR;
                        r_rvalid   <= 1'b1;
                        r_arready  <= 1'b0;
                        r_rd_pulse <= w_rd_onehot;
                        r_rstate   <= R_RESP;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
        assign reg_rw_out[32*g +: 32] = r_regs[g];
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign wr_pulse      = r_wr_pulse;
    assign rd_pulse      = r_rd_pulse;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: inputs change on the falling edge,
// outputs are checked on the falling edge, and the register clocks on the rising edge.
module tb_axi_lite_reg_slave;

    logic          clk = 1'b0;
    logic          rstn;
    logic [14:0]   s_axi_awaddr;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [31:0]   s_axi_wdata;
    logic [3:0]    s_axi_wstrb;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [14:0]   s_axi_araddr;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [255:0]  reg_rw_out;
    logic [255:0]  reg_ro_in;
    logic [7:0]    wr_pulse;
    logic [7:0]    rd_pulse;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_lite_reg_slave #(.ADDR_W(15), .NUM_RW(8), .NUM_RO(8)) dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .reg_rw_out(reg_rw_out), .reg_ro_in(reg_ro_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [7:0] pulse);
        int n;
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = d;
        s_axi_wstrb   = s;
        s_axi_wvalid  = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("write_bvalid_seen", s_axi_bvalid, 1);
        resp  = s_axi_bresp;
        pulse = wr_pulse;
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [14:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output logic [7:0] pulse);
        int n;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("read_rvalid_seen", s_axi_rvalid, 1);
        data  = s_axi_rdata;
        resp  = s_axi_rresp;
        pulse = rd_pulse;
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   resp;
        logic [7:0]   pul;
        logic [31:0]  rd;
        logic [255:0] exp_rw;

        rstn = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        for (int i = 0; i < 8; i++) reg_ro_in[32*i +: 32] = 32'h5000_0000 + 32'(i);
        reg_ro_in[31:0] = 32'hCAFE_F00D;
        exp_rw = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_awready", s_axi_awready, 0);
        chk("rst_wready", s_axi_wready, 0);
        chk("rst_arready", s_axi_arready, 0);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_regs", reg_rw_out, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_rd_pulse", rd_pulse, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_awready", s_axi_awready, 1);
        chk("rel_wready", s_axi_wready, 1);
        chk("rel_arready", s_axi_arready, 1);

        // AW and W together at 0x004
        s_axi_awaddr = 15'h004; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hA5A5_1234; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("t1_bvalid", s_axi_bvalid, 1);
        chk("t1_bresp", s_axi_bresp, 2'b00);
        chk("t1_reg1", reg_rw_out[63:32], 32'hA5A5_1234);
        chk("t1_wr_pulse", wr_pulse, 8'h02);
        chk("t1_awready_low", s_axi_awready, 0);
        @(negedge clk);
        chk("t1_wr_pulse_once", wr_pulse, 8'h00);
        chk("t1_bvalid_hold", s_axi_bvalid, 1);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        chk("t1_bvalid_done", s_axi_bvalid, 0);
        chk("t1_awready_back", s_axi_awready, 1);
        chk("t1_wready_back", s_axi_wready, 1);
        exp_rw[63:32] = 32'hA5A5_1234;

        // AW three cycles ahead of W at 0x008, partial strobe
        s_axi_awaddr = 15'h008; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        chk("t2_awready_held", s_axi_awready, 0);
        chk("t2_wready_open", s_axi_wready, 1);
        chk("t2_no_bvalid", s_axi_bvalid, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t2_awready_wait", s_axi_awready, 0);
            chk("t2_bvalid_wait", s_axi_bvalid, 0);
        end
        s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'b0101; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        chk("t2_bvalid", s_axi_bvalid, 1);
        chk("t2_bresp", s_axi_bresp, 2'b00);
        chk("t2_reg2", reg_rw_out[95:64], 32'h00FF_00FF);
        chk("t2_wr_pulse", wr_pulse, 8'h04);
        @(negedge clk);
        chk("t2_awready_bpend", s_axi_awready, 0);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        chk("t2_awready_back", s_axi_awready, 1);
        exp_rw[95:64] = 32'h00FF_00FF;

        // RO read at 0x100 with a stalled R channel
        s_axi_araddr = 15'h100; s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        reg_ro_in[31:0] = 32'h0000_0000;
        chk("t3_rvalid", s_axi_rvalid, 1);
        chk("t3_rdata", s_axi_rdata, 32'hCAFE_F00D);
        chk("t3_rresp", s_axi_rresp, 2'b00);
        chk("t3_rd_pulse", rd_pulse, 8'h01);
        chk("t3_arready_low", s_axi_arready, 0);
        repeat (5) begin
            @(negedge clk);
            chk("t3_rvalid_hold", s_axi_rvalid, 1);
            chk("t3_rdata_hold", s_axi_rdata, 32'hCAFE_F00D);
            chk("t3_arready_hold", s_axi_arready, 0);
            chk("t3_rd_pulse_once", rd_pulse, 8'h00);
        end
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        chk("t3_rvalid_done", s_axi_rvalid, 0);
        chk("t3_arready_back", s_axi_arready, 1);
        reg_ro_in[31:0] = 32'hCAFE_F00D;

        // Error responses and decode boundaries
        do_write(15'h104, 32'hFFFF_FFFF, 4'hF, resp, pul);
        chk("t4_ro_bresp", resp, 2'b10);
        chk("t4_ro_pulse", pul, 8'h00);
        chk("t4_ro_regs", reg_rw_out, exp_rw);
        do_write(15'h7FFC, 32'hFFFF_FFFF, 4'hF, resp, pul);
        chk("t4_unm_bresp", resp, 2'b10);
        chk("t4_unm_pulse", pul, 8'h00);
        chk("t4_unm_regs", reg_rw_out, exp_rw);
        do_write(15'h020, 32'h1234_5678, 4'hF, resp, pul);
        chk("t4_rw_end_bresp", resp, 2'b10);
        chk("t4_rw_end_regs", reg_rw_out, exp_rw);
        do_write(15'h01C, 32'h7777_0007, 4'hF, resp, pul);
        exp_rw[255:224] = 32'h7777_0007;
        chk("t4_last_bresp", resp, 2'b00);
        chk("t4_last_pulse", pul, 8'h80);
        chk("t4_last_regs", reg_rw_out, exp_rw);
        do_write(15'h004, 32'hFFFF_FFFF, 4'b0000, resp, pul);
        chk("t4_nostrb_bresp", resp, 2'b00);
        chk("t4_nostrb_pulse", pul, 8'h02);
        chk("t4_nostrb_regs", reg_rw_out, exp_rw);
        do_read(15'h7FFC, rd, resp, pul);
        chk("t4_rd_unm_data", rd, 32'h0);
        chk("t4_rd_unm_resp", resp, 2'b10);
        chk("t4_rd_unm_pulse", pul, 8'h00);
        do_read(15'h120, rd, resp, pul);
        chk("t4_rd_ro_end_data", rd, 32'h0);
        chk("t4_rd_ro_end_resp", resp, 2'b10);
        do_read(15'h11C, rd, resp, pul);
        chk("t4_rd_ro7_data", rd, 32'h5000_0007);
        chk("t4_rd_ro7_resp", resp, 2'b00);
        chk("t4_rd_ro7_pulse", pul, 8'h80);
        do_read(15'h004, rd, resp, pul);
        chk("t4_rd_rw1_data", rd, 32'hA5A5_1234);
        chk("t4_rd_rw1_pulse", pul, 8'h00);
        do_read(15'h00A, rd, resp, pul);
        chk("t4_rd_lsb_ignored", rd, 32'h00FF_00FF);

        // Read and commit to the same register on the same edge
        do_write(15'h000, 32'h0000_0011, 4'hF, resp, pul);
        s_axi_awaddr = 15'h000; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0000_0022; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 15'h000; s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        chk("t5_rvalid", s_axi_rvalid, 1);
        chk("t5_rdata_old", s_axi_rdata, 32'h0000_0011);
        chk("t5_bvalid", s_axi_bvalid, 1);
        chk("t5_reg0_new", reg_rw_out[31:0], 32'h0000_0022);
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        do_read(15'h000, rd, resp, pul);
        chk("t5_rdata_new", rd, 32'h0000_0022);

        // Asynchronous reset with B and R pending
        s_axi_awaddr = 15'h00C; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 15'h108; s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_wdata = 32'h0000_0099;
        chk("t6_bvalid_pend", s_axi_bvalid, 1);
        chk("t6_rvalid_pend", s_axi_rvalid, 1);
        chk("t6_rd_pulse", rd_pulse, 8'h04);
        #2 rstn = 1'b0;
        #1;
        chk("t6_async_bvalid", s_axi_bvalid, 0);
        chk("t6_async_rvalid", s_axi_rvalid, 0);
        chk("t6_async_awready", s_axi_awready, 0);
        chk("t6_async_wready", s_axi_wready, 0);
        chk("t6_async_arready", s_axi_arready, 0);
        chk("t6_async_regs", reg_rw_out, 0);
        chk("t6_async_rdata", s_axi_rdata, 0);
        chk("t6_async_wr_pulse", wr_pulse, 0);
        chk("t6_async_rd_pulse", rd_pulse, 0);
        s_axi_wvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("t6_rel_awready", s_axi_awready, 1);
        chk("t6_rel_wready", s_axi_wready, 1);

        // A held W is dropped by reset
        s_axi_wdata = 32'hDEAD_0000; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        chk("t6_w_held", s_axi_wready, 0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("t6_w_dropped_ready", s_axi_wready, 1);
        s_axi_awaddr = 15'h010; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        chk("t6_no_stale_commit", s_axi_bvalid, 0);
        s_axi_wdata = 32'h0BAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        chk("t6_fresh_bvalid", s_axi_bvalid, 1);
        chk("t6_fresh_bresp", s_axi_bresp, 2'b00);
        chk("t6_fresh_reg4", reg_rw_out[159:128], 32'h0BAD_BEEF);
        chk("t6_fresh_low_regs", reg_rw_out[127:0], 0);
        chk("t6_fresh_pulse", wr_pulse, 8'h10);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        chk("t6_fresh_done", s_axi_bvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
- AXI-Lite responder (slave) register bank, single clock domain.
- Terminates the m_axi_* master side of the DDR-clock register path.
- Provides NUM_RW read/write control registers and NUM_RO read-only status words.
- Emits per-register write and read strobes for downstream side effects (pulse triggers, FIFO pops).
- Single-beat only. AW and W are accepted independently in any order; reads and writes run concurrently.

Parameters:
- ADDR_W, 15, AXI address width (byte address).
- NUM_RW, 8, number of RW registers at byte offset 0x000 + 4*i (1..64).
- NUM_RO, 8, number of RO words at byte offset 0x100 + 4*i (1..64).

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  ADDR_W  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read valid.
- s_axi_rready  in  1  read ready.
- reg_rw_out  out  NUM_RW*32  RW register contents; register i occupies bits [32*i+31:32*i].
- reg_ro_in  in  NUM_RO*32  status words, sampled at read acceptance.
- wr_pulse  out  NUM_RW  one-cycle strobe per committed write to RW register i.
- rd_pulse  out  NUM_RO  one-cycle strobe per accepted read of RO word i.

Behaviour:
- Reset values: all outputs 0; all RW registers 0; both FSMs in IDLE. Async assert, sync release.
- Address decode:
  - Word index = addr[ADDR_W-1:2]; addr[1:0] ignored.
  - RW hit: index < NUM_RW.
  - RO hit: 64 <= index < 64+NUM_RO.
  - Anything else is unmapped.
- Write path, states W_IDLE and W_RESP:
  - In W_IDLE, awready = !aw_held and wready = !w_held. Both are registered: low in reset, high from the first edge after release.
  - An AW handshake latches the address into aw_held. A W handshake latches data and strobe into w_held. Order is free; both may occur in the same cycle.
  - On the edge where both are held (including a simultaneous final handshake), the write commits:
    - RW hit: bytes with wstrb=1 are updated, wr_pulse[i]=1 for exactly the next cycle, bresp=OKAY (00).
    - RO hit or unmapped: no state change, no pulse, bresp=SLVERR (10).
  - Also on the commit edge: bvalid<=1, held flags clear, awready/wready<=0, go to W_RESP.
  - Latency: bvalid is high in the cycle after the last of the AW/W handshakes.
  - W_RESP: hold bvalid and bresp stable until bvalid&&bready. Then bvalid<=0, awready/wready<=1, return to W_IDLE. No new AW/W is accepted while bvalid=1.
- Read path, states R_IDLE and R_RESP:
  - arready is high in R_IDLE (registered, low in reset).
  - On arvalid&&arready:
    - rdata = register value (RW hit) or reg_ro_in word (RO hit), rresp=OKAY.
    - Unmapped: rdata=0, rresp=SLVERR.
    - rvalid<=1, arready<=0, go to R_RESP.
    - RO hit: rd_pulse[i]=1 for exactly the next cycle.
  - Latency: rvalid is high in the cycle after the AR handshake.
  - R_RESP: rdata, rresp and rvalid stay stable until rready. Then rvalid<=0, arready<=1, return to R_IDLE.
- Simultaneous read and commit to the same RW register on the same edge: the read returns the pre-write value.
- wstrb=0000 to an RW hit: no data change, but wr_pulse still fires and bresp=OKAY.
- Reset mid-transaction: held AW/W, pending B/R and partial writes are discarded. Registers return to 0.
- All flat-bus packing: index i occupies [32*i+31:32*i].

Test Plan:
- Reset release, then AW+W same cycle: addr 0x004, data 0xA5A5_1234, strb 1111 -> bvalid next cycle, bresp 00, reg_rw_out[63:32]=0xA5A5_1234, wr_pulse=0000_0010 for 1 cycle.
- AW at 0x008 three cycles before W (data 0xFFFF_FFFF, strb 0101), register preloaded 0 -> register=0x00FF_00FF. awready stays low after AW until B completes.
- Read 0x100 with reg_ro_in[31:0]=0xCAFE_F00D -> rvalid one cycle after AR, rdata 0xCAFE_F00D, rresp 00, rd_pulse[0] single cycle. Hold rready=0 for 5 cycles -> rdata stable, arready low throughout.
- Write 0x104 (RO) and 0x7FFC (unmapped) -> bresp 10, no register change, no wr_pulse. Read 0x7FFC -> rdata 0, rresp 10.
- Same-cycle AR and commit to 0x000 (old 0x11, new 0x22) -> rdata 0x11; a subsequent read returns 0x22.
- Assert rstn low while bvalid=1 and a W is held -> all outputs 0 immediately; after release, a fresh write completes normally.
